// File: rtl/lcd_pkg.sv
// Shared LCD definitions: word layout, DC encodings and the transmit
// state machine encoding used by the SPI transmit stage.
package lcd_pkg;

   localparam int LCD_WORD_W = 9;
   localparam int LCD_DC_BIT = 8;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/lcd_tx_fifo.sv
// Small synchronous word FIFO feeding the LCD serialiser.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate counter; the head word is read combinationally so
// the serialiser can latch it on the same edge it enters LOAD.
module lcd_tx_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic                        clk_50MHz,
   input  logic                        rst_n,
   input  logic                        i_push,
   input  logic [LCD_WORD_W-1:0]       i_data,
   input  logic                        i_pop,
   output logic [LCD_WORD_W-1:0]       o_head,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [$clog2(DEPTH):0]      o_level
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [LCD_WORD_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]       r_wr_ptr;
   logic [ADDR_W:0]       r_rd_ptr;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;

   assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);

   // A full FIFO refuses the write even if a pop frees a slot this cycle.
   assign w_push  = i_push && !w_full;
   assign w_pop   = i_pop && !w_empty;

   // Storage write; contents need no reset because the pointers gate them.
   always_ff @(posedge clk_50MHz) begin
      if (w_push) begin
         r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
      end
   end

   // Pointer update with natural wrap of the extra MSB.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
         end
      end
   end

   assign o_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/lcd_spi_tx_fifo.sv
// Buffered SPI (mode 0) transmit stage for the ST7789-class LCD.
// Producers push 9-bit {dc, byte} words; each is shifted out MSB first.
// CS stays low across queued bytes unless LCD_TX_CS_PER_BYTE_EN is
// defined, in which case CS is released for CS_GAP cycles after every byte.
// All LCD pins are registered so they never glitch.
module lcd_spi_tx_fifo
   import lcd_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int CS_GAP     = 2
)
(
   input  logic                          clk_50MHz,
   input  logic                          rst_n,
   input  logic [LCD_WORD_W-1:0]         in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          lcd_sclk,
   output logic                          lcd_mosi,
   output logic                          lcd_cs,
   output logic                          lcd_dc,
   output logic                          wr_done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam int         GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   tx_state_t             r_state;
   tx_state_t             w_state_next;
   logic                  w_pop;

   logic [LCD_WORD_W-1:0] w_head;
   logic                  w_full;
   logic                  w_empty;

   logic [6:0]            r_shift;
   logic [7:0]            r_div_cnt;
   logic [3:0]            r_bit_cnt;
   logic [GAP_W-1:0]      r_gap_cnt;
   logic                  r_sclk;
   logic                  r_mosi;
   logic                  r_cs;
   logic                  r_dc;
   logic                  r_wr_done;

   logic                  w_div_term;
   logic                  w_fall;
   logic                  w_last;

   lcd_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .i_push    (in_valid),
      .i_data    (in_data),
      .i_pop     (w_pop),
      .o_head    (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (fifo_level)
   );

   assign w_div_term = (r_div_cnt == DIV_LAST);
   assign w_fall     = (r_state == SHIFT) && w_div_term && r_sclk;
   assign w_last     = w_fall && (r_bit_cnt == 4'd7);

   // State register.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode; the FIFO head is consumed during the LOAD cycle.
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_state_next = LOAD;
            end
         end
         LOAD: begin
            w_pop        = 1'b1;
            w_state_next = SHIFT;
         end
         SHIFT: begin
            if (w_last) begin
`ifdef LCD_TX_CS_PER_BYTE_EN
               w_state_next = HOLD;
`else
               w_state_next = w_empty ? HOLD : LOAD;
`endif
            end
         end
         HOLD: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Serial datapath: latch the head on LOAD entry, toggle SCLK every
   // CLK_DIV cycles, advance MOSI only on falling edges.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
         r_cs      <= 1'b1;
         r_dc      <= 1'b0;
         r_wr_done <= 1'b0;
      end else begin
         r_wr_done <= w_last;
         if (w_state_next == LOAD) begin
            r_shift   <= w_head[6:0];
            r_mosi    <= w_head[7];
            r_dc      <= w_head[LCD_DC_BIT];
            r_cs      <= 1'b0;
            r_sclk    <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
         end else begin
            case (r_state)
               SHIFT: begin
                  if (w_div_term) begin
                     r_div_cnt <= '0;
                     r_sclk    <= ~r_sclk;
                     if (r_sclk) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_shift   <= {r_shift[5:0], 1'b0};
                        r_mosi    <= r_shift[6];
                     end
                     if (w_last) begin
                        r_cs      <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_gap_cnt <= '0;
                     end
                  end else begin
                     r_div_cnt <= r_div_cnt + 8'd1;
                  end
               end
               HOLD: begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign in_ready = !w_full;
   assign busy     = (r_state != IDLE) || !w_empty;
   assign lcd_sclk = r_sclk;
   assign lcd_mosi = r_mosi;
   assign lcd_cs   = r_cs;
   assign lcd_dc   = r_dc;
   assign wr_done  = r_wr_done;

endmodule

// File: doc/lcd_spi_tx_fifo.md
Name: lcd_spi_tx_fifo

Overview:
- Buffered SPI transmit stage for the ST7789-class LCD.
- Sits directly downstream of the pixel/emoji generators and the init sequencer.
- Accepts 9-bit LCD words {dc, byte} over a valid/ready handshake and queues them in a small FIFO.
- Serialises each word MSB-first onto SCLK/MOSI in SPI mode 0, with CS/DC management. Producers can therefore run burst-wise instead of waiting on wr_done per byte.

Parameters:
- CLK_DIV, 2: clk_50MHz cycles per SCLK half-period (SCLK = 50MHz/(2*CLK_DIV)); legal range 1..255.
- FIFO_DEPTH, 16: word entries; power of two, at least 2.
- CS_GAP, 2: minimum clk cycles CS stays high between bursts; at least 1.

Ports:
- clk_50MHz  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  9  bit8 = dc (1 = pixel/param data, 0 = command); bits7:0 = byte.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO can accept; equals !full (registered-state based).
- lcd_sclk  out  1  SPI clock, idle low.
- lcd_mosi  out  1  SPI data, MSB first.
- lcd_cs  out  1  chip select, active low.
- lcd_dc  out  1  data/command for the byte currently shifting.
- wr_done  out  1  one-cycle pulse when a byte's last SCLK falling edge completes.
- busy  out  1  high when state != IDLE or FIFO not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values (async, takes effect immediately, including mid-byte):
  - lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, wr_done=0, busy=0, fifo_level=0, in_ready=1.
  - FIFO pointers cleared; any partial byte is abandoned and never resumed.
- Push: occurs on a cycle where in_valid && in_ready. When full, in_ready=0 and in_data is ignored, even if a pop happens in the same cycle.
- Simultaneous push and pop when not full and not empty: level unchanged.
- Pop: only in LOAD.
- State machine IDLE, LOAD, SHIFT, HOLD:
  - IDLE: cs=1, sclk=0. Go to LOAD when FIFO not empty.
  - LOAD (1 cycle):
    - Pop head into shift_reg.
    - Drive lcd_dc=word[8], lcd_mosi=word[7], lcd_cs=0.
    - Clear div_cnt and bit_cnt=0. Go to SHIFT.
  - SHIFT:
    - div_cnt counts 0..CLK_DIV-1; at terminal count, toggle sclk.
    - Rising edge: slave samples; no MOSI change.
    - Falling edge: bit_cnt++; if bit_cnt<8, mosi gets the next lower bit.
    - After the 8th falling edge: assert wr_done for 1 cycle.
    - Next state: LOAD if FIFO not empty (CS stays low, no gap); otherwise HOLD.
  - HOLD: cs=1 and count CS_GAP cycles, then go to IDLE.
- Timing:
  - SHIFT lasts exactly 16*CLK_DIV cycles per byte.
  - Back-to-back byte period is 16*CLK_DIV+1 cycles (33 at default).
  - Latency from accepted push into an empty idle FIFO to cs falling is 2 cycles (FIFO write, then IDLE→LOAD).
  - First SCLK rise occurs CLK_DIV cycles after LOAD.
- lcd_dc changes only in LOAD, so it is stable for the whole byte.
- Pointers are $clog2(FIFO_DEPTH)+1 bits with natural wrap. Full is flagged when MSBs differ and the rest are equal.

Optional Feature:
- LCD_TX_CS_PER_BYTE_EN defined:
  - After every byte, SHIFT always goes to HOLD, so CS is high for CS_GAP cycles between every byte.
  - Byte period becomes 16*CLK_DIV+CS_GAP+2 cycles.
- Not defined: CS is held low across consecutive queued bytes, as described above.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD_WORD_W=9 and LCD_DC_BIT=8.
  - DC_CMD=0 and DC_DATA=1.
  - The tx state enum {IDLE, LOAD, SHIFT, HOLD}.
- One natural sub-module: lcd_tx_fifo, a synchronous FIFO with push/pop, full/empty and level outputs. The serialiser FSM stays in the top module.

Test Plan:
- Reset then idle: after rst_n release with no input, cs=1, sclk=0, in_ready=1, busy=0, fifo_level=0 for 100 cycles.
- Single command: push 9'h02A (CLK_DIV=2):
  - cs falls 2 cycles later and dc=0.
  - Bench samples MOSI on 8 SCLK rises and must read 8'h2A.
  - wr_done pulses once, after 32 SHIFT cycles.
  - cs returns high and stays high for CS_GAP=2 cycles before IDLE.
- Burst of 4 data words 9'h1F8, 9'h100, 9'h1FF, 9'h1E0, pushed consecutively:
  - cs stays low throughout, dc=1.
  - Received bytes are F8, 00, FF, E0, 33 cycles apart.
  - Exactly 4 wr_done pulses.
- Full FIFO: hold in_valid for 20 words with no drain opportunity before the first LOAD:
  - in_ready drops when fifo_level reaches 16.
  - Blocked words are not lost; the producer holds them.
  - Output order is preserved.
- Command/data mix 9'h02C then 9'h112: dc goes low for the first byte and high for the second; each changes only at LOAD.
- Reset mid-byte after 3 SCLK rises: outputs go to reset values immediately and fifo_level=0. A subsequent push of 9'h155 transmits 8'h55 cleanly.
